// File: rtl/core_pkg.sv
// Shared types and default limits for the core's memory port arbiter.
package core_pkg;

  localparam int unsigned DEF_MAX_DM_STREAK = 4;
  localparam int unsigned DEF_TIMEOUT       = 15;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_GNT  = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    OWN_IF = 2'd1,
    OWN_DM = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Transaction timeout: loads on grant, counts down while a transaction is open,
// and flags expiry in the TIMEOUT-th cycle spent waiting on memory.
module mem_arb_timer
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_run,
  output logic o_expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(TIMEOUT - 1);
    end else if (i_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expire = i_run & (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the data path with a
// single outstanding transaction, DM-first priority and an IF anti-starvation limit.
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned MAX_DM_STREAK = DEF_MAX_DM_STREAK,
  parameter int unsigned TIMEOUT       = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_W-1:0]     if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_W-1:0]     if_rdata_o,
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [ADDR_W-1:0]     dm_addr_i,
  input  logic [DATA_W-1:0]     dm_wdata_i,
  input  logic [DATA_W/8-1:0]   dm_be_i,
  output logic                  dm_gnt_o,
  output logic                  dm_rvalid_o,
  output logic [DATA_W-1:0]     dm_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  output logic [DATA_W/8-1:0]   mem_be_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  output logic                  stall_o,
  output logic                  err_o
);

  localparam int unsigned STREAK_W = $clog2(MAX_DM_STREAK + 1);

  arb_state_t            r_state;
  arb_state_t            w_next_state;
  arb_owner_t            r_owner;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W/8-1:0]   r_be;
  logic [STREAK_W-1:0]   r_dm_streak;

  logic w_streak_max;
  logic w_grant_if;
  logic w_grant_dm;
  logic w_grant;
  logic w_expire;
  logic w_resp;
  logic w_abort;

  // DM wins ties unless IF has already waited out MAX_DM_STREAK DM grants.
  assign w_streak_max = (r_dm_streak == STREAK_W'(MAX_DM_STREAK));
  assign w_grant_dm   = ~rst & (r_state == IDLE) & dm_req_i & ~(if_req_i & w_streak_max);
  assign w_grant_if   = ~rst & (r_state == IDLE) & if_req_i & ~w_grant_dm;
  assign w_grant      = w_grant_if | w_grant_dm;
  assign w_resp       = (r_state == WAIT_RESP) & mem_rvalid_i & (r_owner != NONE);
  assign w_abort      = w_expire & ~w_resp;

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_grant),
    .i_run    (r_state != IDLE),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant) w_next_state = WAIT_GNT;
      end
      WAIT_GNT: begin
        if (w_abort)        w_next_state = IDLE;
        else if (mem_gnt_i) w_next_state = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (w_resp | w_abort) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Request payload is captured at grant so mem_* stay stable while the requester moves on.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= NONE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_grant) begin
      r_owner <= w_grant_dm ? OWN_DM : OWN_IF;
      r_we    <= w_grant_dm & dm_we_i;
      r_addr  <= w_grant_dm ? dm_addr_i : if_addr_i;
      r_wdata <= (w_grant_dm & dm_we_i) ? dm_wdata_i : '0;
      r_be    <= (w_grant_dm & dm_we_i) ? dm_be_i : '1;
    end else if (w_next_state == IDLE) begin
      r_owner <= NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dm_streak <= '0;
    end else if (~if_req_i | w_grant_if) begin
      r_dm_streak <= '0;
    end else if (w_grant_dm & ~w_streak_max) begin
      r_dm_streak <= r_dm_streak + STREAK_W'(1);
    end
  end

  always_comb begin
    if_gnt_o    = 1'b0;
    dm_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    dm_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    dm_rdata_o  = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    stall_o     = 1'b0;
    err_o       = 1'b0;
    if (!rst) begin
      if_gnt_o    = w_grant_if;
      dm_gnt_o    = w_grant_dm;
      if_rvalid_o = (w_resp | w_abort) & (r_owner == OWN_IF);
      dm_rvalid_o = (w_resp | w_abort) & (r_owner == OWN_DM);
      if (w_resp & ~r_we) begin
        if (r_owner == OWN_IF) if_rdata_o = mem_rdata_i;
        if (r_owner == OWN_DM) dm_rdata_o = mem_rdata_i;
      end
      mem_req_o   = (r_state == WAIT_GNT) & ~w_expire;
      mem_we_o    = r_we;
      mem_addr_o  = r_addr;
      mem_wdata_o = r_wdata;
      mem_be_o    = r_be;
      stall_o     = (r_state != IDLE) | (if_req_i & ~w_grant_if) | (dm_req_i & ~w_grant_dm);
      err_o       = w_abort;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with hand-computed values, then random traffic.
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXS = 4;
  localparam int unsigned TO   = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_req_i;
  logic [AW-1:0]   if_addr_i;
  logic            if_gnt_o, if_rvalid_o;
  logic [DW-1:0]   if_rdata_o;
  logic            dm_req_i, dm_we_i;
  logic [AW-1:0]   dm_addr_i;
  logic [DW-1:0]   dm_wdata_i;
  logic [DW/8-1:0] dm_be_i;
  logic            dm_gnt_o, dm_rvalid_o;
  logic [DW-1:0]   dm_rdata_o;
  logic            mem_req_o, mem_we_o;
  logic [AW-1:0]   mem_addr_o;
  logic [DW-1:0]   mem_wdata_o;
  logic [DW/8-1:0] mem_be_o;
  logic            mem_gnt_i, mem_rvalid_i;
  logic [DW-1:0]   mem_rdata_i;
  logic            stall_o, err_o;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_DM_STREAK(MAXS), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_be_i(dm_be_i), .dm_gnt_o(dm_gnt_o),
    .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Reference model: one open transaction, its age in cycles since grant,
  // whether memory has accepted it, and the DM-over-IF win count.
  bit              m_busy, m_acc, m_we;
  int              m_age, m_owner, m_streak;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [DW/8-1:0] m_be;
  logic            e_if_gnt, e_dm_gnt, e_if_rv, e_dm_rv, e_mem_req, e_stall, e_err;
  logic [DW-1:0]   e_if_rd, e_dm_rd;

  initial begin : model_proc
    bit done, abort;
    m_busy = 0; m_acc = 0; m_we = 0; m_age = 0; m_owner = 0; m_streak = 0;
    m_addr = '0; m_wdata = '0; m_be = '0;
    forever begin
      @(negedge clk); #1;
      e_if_gnt = 0; e_dm_gnt = 0; e_if_rv = 0; e_dm_rv = 0; e_mem_req = 0;
      e_stall = 0; e_err = 0; e_if_rd = '0; e_dm_rd = '0; done = 0; abort = 0;
      if (!rst) begin
        if (!m_busy) begin
          if (dm_req_i && !(if_req_i && m_streak == int'(MAXS))) e_dm_gnt = 1;
          else if (if_req_i) e_if_gnt = 1;
        end else begin
          done      = m_acc && mem_rvalid_i;
          abort     = !done && (m_age == int'(TO));
          e_mem_req = !m_acc && (m_age < int'(TO));
          e_err     = abort;
          if (done || abort) begin
            if (m_owner == 1) e_if_rv = 1; else e_dm_rv = 1;
          end
          if (done && !m_we) begin
            if (m_owner == 1) e_if_rd = mem_rdata_i; else e_dm_rd = mem_rdata_i;
          end
        end
        e_stall = m_busy | (if_req_i & !e_if_gnt) | (dm_req_i & !e_dm_gnt);
      end
      chk("if_gnt", 64'(if_gnt_o), 64'(e_if_gnt));
      chk("dm_gnt", 64'(dm_gnt_o), 64'(e_dm_gnt));
      chk("if_rvalid", 64'(if_rvalid_o), 64'(e_if_rv));
      chk("dm_rvalid", 64'(dm_rvalid_o), 64'(e_dm_rv));
      chk("if_rdata", 64'(if_rdata_o), 64'(e_if_rd));
      chk("dm_rdata", 64'(dm_rdata_o), 64'(e_dm_rd));
      chk("mem_req", 64'(mem_req_o), 64'(e_mem_req));
      chk("stall", 64'(stall_o), 64'(e_stall));
      chk("err", 64'(err_o), 64'(e_err));
      if (rst) begin
        chk("rst_mem_addr", 64'(mem_addr_o), 64'd0);
        chk("rst_mem_be", 64'(mem_be_o), 64'd0);
      end else if (e_mem_req) begin
        chk("mem_we", 64'(mem_we_o), 64'(m_we));
        chk("mem_addr", 64'(mem_addr_o), 64'(m_addr));
        chk("mem_wdata", 64'(mem_wdata_o), 64'(m_wdata));
        chk("mem_be", 64'(mem_be_o), 64'(m_be));
      end
      if (rst) begin
        m_busy = 0; m_streak = 0;
      end else begin
        if (!if_req_i || e_if_gnt) m_streak = 0;
        else if (e_dm_gnt && m_streak < int'(MAXS)) m_streak++;
        if (m_busy) begin
          if (done || abort) m_busy = 0;
          else begin
            if (e_mem_req && mem_gnt_i) m_acc = 1;
            m_age++;
          end
        end else if (e_if_gnt || e_dm_gnt) begin
          m_busy  = 1; m_acc = 0; m_age = 1;
          m_owner = e_dm_gnt ? 2 : 1;
          m_we    = e_dm_gnt && dm_we_i;
          m_addr  = e_dm_gnt ? dm_addr_i : if_addr_i;
          m_wdata = m_we ? dm_wdata_i : '0;
          m_be    = m_we ? dm_be_i : '1;
        end
      end
    end
  end

  initial begin : stim
    string seq;
    int n_req, n_err, err_cyc, rv_cyc, gnt_pct;
    logic [DW-1:0] rv_data;
    logic stall16;
    rst = 1; if_req_i = 0; if_addr_i = '0; dm_req_i = 0; dm_we_i = 0;
    dm_addr_i = '0; dm_wdata_i = '0; dm_be_i = '0; mem_gnt_i = 0;
    mem_rvalid_i = 0; mem_rdata_i = '0;
    repeat (3) cyc();
    cyc(); rst = 0; #2;
    chk("reset_gnt", 64'({if_gnt_o, dm_gnt_o}), 64'd0);
    chk("reset_req_stall_err", 64'({mem_req_o, stall_o, err_o}), 64'd0);
    chk("reset_mem_addr", 64'(mem_addr_o), 64'd0);

    // IF read, memory accepts immediately and answers two cycles later
    cyc(); if_req_i = 1; if_addr_i = 32'h100; #2;
    chk("t1_if_gnt_c0", 64'(if_gnt_o), 64'd1);
    chk("t1_mem_req_c0", 64'(mem_req_o), 64'd0);
    cyc(); if_req_i = 0; mem_gnt_i = 1; #2;
    chk("t1_mem_req_c1", 64'(mem_req_o), 64'd1);
    chk("t1_mem_addr", 64'(mem_addr_o), 64'h100);
    chk("t1_mem_be_we", 64'({mem_be_o, mem_we_o}), 64'b11110);
    cyc(); mem_gnt_i = 0; #2;
    chk("t1_mem_req_c2", 64'(mem_req_o), 64'd0);
    cyc(); mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF; #2;
    chk("t1_if_rvalid_c3", 64'(if_rvalid_o), 64'd1);
    chk("t1_if_rdata_c3", 64'(if_rdata_o), 64'hDEADBEEF);
    cyc(); mem_rvalid_i = 0; #2;
    chk("t1_stall_after", 64'(stall_o), 64'd0);

    // DM store beats a simultaneous IF fetch
    cyc(); if_req_i = 1; if_addr_i = 32'h300; dm_req_i = 1; dm_we_i = 1;
    dm_addr_i = 32'h200; dm_be_i = 4'b0011; dm_wdata_i = 32'h12345678; #2;
    chk("t2_gnts", 64'({dm_gnt_o, if_gnt_o}), 64'b10);
    chk("t2_stall", 64'(stall_o), 64'd1);
    cyc(); dm_req_i = 0; dm_we_i = 0; mem_gnt_i = 1; #2;
    chk("t2_mem", 64'({mem_we_o, mem_be_o}), 64'b10011);
    chk("t2_mem_addr", 64'(mem_addr_o), 64'h200);
    cyc(); mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hFFFFFFFF; #2;
    chk("t2_dm_rvalid", 64'(dm_rvalid_o), 64'd1);
    chk("t2_dm_rdata", 64'(dm_rdata_o), 64'd0);
    cyc(); mem_rvalid_i = 0; #2;
    chk("t2_if_gnt_next", 64'(if_gnt_o), 64'd1);
    cyc(); if_req_i = 0; mem_gnt_i = 1;
    cyc(); mem_gnt_i = 0; mem_rvalid_i = 1;
    cyc(); mem_rvalid_i = 0;
    repeat (2) cyc();

    // Both requesters saturate the port; IF must win every fifth grant
    cyc(); if_req_i = 1; dm_req_i = 1; dm_we_i = 0; mem_gnt_i = 1; mem_rvalid_i = 1;
    seq = "";
    for (int c = 0; c < 60 && seq.len() < 10; c++) begin
      if (c > 0) cyc();
      #2;
      if (dm_gnt_o) seq = {seq, "D"};
      else if (if_gnt_o) seq = {seq, "I"};
    end
    n_checks++;
    if (seq != "DDDDIDDDDI") begin
      n_errors++;
      $display("FAIL grant_seq: got '%s' expected 'DDDDIDDDDI'", seq);
    end
    cyc(); if_req_i = 0; dm_req_i = 0;
    repeat (4) cyc();
    cyc(); mem_gnt_i = 0; mem_rvalid_i = 0;
    repeat (2) cyc();

    // Memory never accepts: abort in the TIMEOUT-th waiting cycle
    cyc(); dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h400; #2;
    chk("t4_dm_gnt", 64'(dm_gnt_o), 64'd1);
    n_req = 0; n_err = 0; err_cyc = -1; rv_cyc = -1; rv_data = 'x; stall16 = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      cyc(); if (k == 1) dm_req_i = 0; #2;
      if (mem_req_o) n_req++;
      if (err_o) begin n_err++; err_cyc = k; end
      if (dm_rvalid_o) begin rv_cyc = k; rv_data = dm_rdata_o; end
      if (k == 16) stall16 = stall_o;
    end
    chk("t4_err_count", 64'(n_err), 64'd1);
    chk("t4_err_cycle", 64'(err_cyc), 64'd15);
    chk("t4_rvalid_cycle", 64'(rv_cyc), 64'd15);
    chk("t4_rvalid_data", 64'(rv_data), 64'd0);
    chk("t4_mem_req_cycles", 64'(n_req), 64'd14);
    chk("t4_stall_idle", 64'(stall16), 64'd0);

    // Reset during the response phase abandons the transaction silently
    cyc(); dm_req_i = 1; dm_addr_i = 32'h480;
    cyc(); dm_req_i = 0; mem_gnt_i = 1;
    cyc(); mem_gnt_i = 0; rst = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h55AA55AA; #2;
    chk("t5_rst_rvalid_err", 64'({dm_rvalid_o, if_rvalid_o, err_o}), 64'd0);
    chk("t5_rst_outputs", 64'({mem_req_o, stall_o, dm_rdata_o}), 64'd0);
    cyc(); #2;
    chk("t5_rst_rvalid_2", 64'(dm_rvalid_o), 64'd0);
    cyc(); rst = 0; #2;
    chk("t5_post_rst_rvalid", 64'({dm_rvalid_o, if_rvalid_o, err_o}), 64'd0);
    cyc(); mem_rvalid_i = 0; if_req_i = 1; if_addr_i = 32'h500; #2;
    chk("t5_if_gnt", 64'(if_gnt_o), 64'd1);
    cyc(); if_req_i = 0; mem_gnt_i = 1;
    cyc(); mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hCAFEF00D; #2;
    chk("t5_if_rdata", 64'({if_rvalid_o, if_rdata_o}), {31'd0, 1'b1, 32'hCAFEF00D});
    cyc(); mem_rvalid_i = 0;

    // Slow memory accept: latched payload must not follow the moving DM inputs
    cyc(); dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h600; dm_wdata_i = 32'hA5A5A5A5;
    dm_be_i = 4'b1100; #2;
    chk("t6_dm_gnt", 64'(dm_gnt_o), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      cyc(); dm_req_i = 0; dm_addr_i = $urandom; dm_wdata_i = $urandom;
      dm_be_i = 4'($urandom); mem_gnt_i = (k == 4); #2;
      chk("t6_mem_req", 64'(mem_req_o), 64'd1);
      chk("t6_mem_addr", 64'(mem_addr_o), 64'h600);
      chk("t6_mem_wdata_be", 64'({mem_wdata_o, mem_be_o}), {28'd0, 32'hA5A5A5A5, 4'b1100});
    end
    cyc(); mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h11112222; #2;
    chk("t6_store_ack", 64'({dm_rvalid_o, dm_rdata_o}), {31'd0, 1'b1, 32'd0});
    cyc(); mem_rvalid_i = 0; dm_we_i = 0;
    repeat (2) cyc();

    // Random traffic against the model
    gnt_pct = 60;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (c % 200 == 0) begin
        case ($urandom_range(0, 2))
          0:       gnt_pct = 70;
          1:       gnt_pct = 25;
          default: gnt_pct = 3;
        endcase
      end
      rst = ($urandom_range(0, 399) == 0);
      if (!(if_req_i && !e_if_gnt)) begin
        if_req_i  = ($urandom_range(0, 2) == 0);
        if_addr_i = $urandom;
      end
      if (!(dm_req_i && !e_dm_gnt)) begin
        dm_req_i   = ($urandom_range(0, 2) == 0);
        dm_we_i    = 1'($urandom);
        dm_addr_i  = $urandom;
        dm_wdata_i = $urandom;
        dm_be_i    = 4'($urandom);
      end
      mem_gnt_i    = ($urandom_range(0, 99) < gnt_pct);
      mem_rvalid_i = ($urandom_range(0, 99) < 35);
      mem_rdata_i  = $urandom;
    end
    cyc(); rst = 0; if_req_i = 0; dm_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    repeat (3) cyc();
    #3;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
